stream_fifo_clearable: RTL and testbench



---
 rtl/stream_fifo_clearable.sv | 127 ++++++++++++
 tb/tb_stream_fifo_clearable.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_clearable.sv
// Single-clock valid/ready FIFO with a sequenced warm clear (IDLE -> ISOLATE -> CLEAR).
// Optional zero-latency bypass when empty: define STREAM_FIFO_CLEARABLE_FALL_THROUGH_EN.
module stream_fifo_clearable #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int DRAIN      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    output logic                         clear_pending_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake contract: a beat transfers on a rising edge where valid and ready
    // are both high; valid never waits on ready, and data is stable while valid.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full, empty, is_idle;
    logic mem_valid, ft_active, bypass;
    logic push_fire, pop_fire, wr_en, rd_en;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign is_idle = (state_q == IDLE);

`ifdef STREAM_FIFO_CLEARABLE_FALL_THROUGH_EN
    assign ft_active = is_idle && empty;
`else
    assign ft_active = 1'b0;
`endif

    // Stored entries stay visible during ISOLATE only when draining.
    assign mem_valid = !empty && (is_idle || ((state_q == ISOLATE) && (DRAIN != 0)));

    assign ready_o         = is_idle && !full;
    assign valid_o         = ft_active ? valid_i : mem_valid;
    assign clear_pending_o = !is_idle;
    assign usage_o         = count_q;

    always_comb begin
        data_o = '0;
        if (ft_active) begin
            if (valid_i) data_o = data_i;
        end else if (mem_valid) begin
            data_o = mem_q[rptr_q];
        end
    end

    assign push_fire = valid_i && ready_o;
    assign pop_fire  = valid_o && ready_i;
    assign bypass    = ft_active && valid_i && ready_i;
    assign wr_en     = push_fire && !bypass;
    assign rd_en     = pop_fire && !bypass;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = next_ptr(wptr_q);
        if (rd_en) rptr_d = next_ptr(rptr_q);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            IDLE: begin
                if (clear_i) state_d = ISOLATE;
            end
            ISOLATE: begin
                // Leave once the pop in this cycle (if any) empties the storage.
                if ((DRAIN == 0) || (count_d == '0)) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = IDLE;
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: tb/tb_stream_fifo_clearable.sv
// Bench for stream_fifo_clearable: a flush-mode and a drain-mode instance (DEPTH=3) share stimulus.
// Honors STREAM_FIFO_CLEARABLE_FALL_THROUGH_EN when defined for the build.
module tb_stream_fifo_clearable;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int UW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic clear_i, valid_i, ready_i;
  logic [W-1:0] data_i;

  logic f_pending, f_ready, f_valid, d_pending, d_ready, d_valid;
  logic [W-1:0] f_data, d_data;
  logic [UW-1:0] f_usage, d_usage;

  int checks = 0;
  int errors = 0;
  int n_pop_f = 0;
  int n_pop_d = 0;
  bit sb_on = 0;
  logic [W-1:0] exp_f[$];
  logic [W-1:0] exp_d[$];

  always #5 clk = ~clk;

  stream_fifo_clearable #(.DATA_WIDTH(W), .DEPTH(D), .DRAIN(0)) u_f (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .clear_pending_o(f_pending),
    .data_i(data_i), .valid_i(valid_i), .ready_o(f_ready),
    .data_o(f_data), .valid_o(f_valid), .ready_i(ready_i), .usage_o(f_usage)
  );

  stream_fifo_clearable #(.DATA_WIDTH(W), .DEPTH(D), .DRAIN(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .clear_pending_o(d_pending),
    .data_i(data_i), .valid_i(valid_i), .ready_o(d_ready),
    .data_o(d_data), .valid_o(d_valid), .ready_i(ready_i), .usage_o(d_usage)
  );

  // Scoreboard: samples settled signals mid-cycle, pushes accepted beats, pops delivered ones.
  task automatic sb_sample();
    logic [W-1:0] e;
    if (valid_i && clear_i) begin
      errors++;
      $display("FAIL input_rule: valid_i=1 with clear_i=1 at %0t", $time);
    end
    if (sb_on) begin
      checks++;
      if (int'(f_usage) != exp_f.size()) begin
        errors++;
        $display("FAIL usage_f: got %0d expected %0d at %0t", f_usage, exp_f.size(), $time);
      end
    end
    if (valid_i && f_ready) exp_f.push_back(data_i);
    if (valid_i && d_ready) exp_d.push_back(data_i);
    if (f_valid && ready_i) begin
      checks++;
      n_pop_f++;
      if (exp_f.size() == 0) begin
        errors++;
        $display("FAIL pop_f: got %02h expected nothing at %0t", f_data, $time);
      end else begin
        e = exp_f.pop_front();
        if (f_data !== e) begin
          errors++;
          $display("FAIL pop_f: got %02h expected %02h at %0t", f_data, e, $time);
        end
      end
    end
    if (d_valid && ready_i) begin
      checks++;
      n_pop_d++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL pop_d: got %02h expected nothing at %0t", d_data, $time);
      end else begin
        e = exp_d.pop_front();
        if (d_data !== e) begin
          errors++;
          $display("FAIL pop_d: got %02h expected %02h at %0t", d_data, e, $time);
        end
      end
    end
  endtask

  // Inputs are set just after a rising edge; checks run at +2, scoreboard at +4.
  task automatic cyc();
    #2;
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; clear_i = 0; valid_i = 0; ready_i = 0; data_i = '0;
    sb_on = 0;
    cyc();
    cyc();
    rst_n = 1;
    exp_f.delete();
    exp_d.delete();
  endtask

  task automatic push_two(input logic [W-1:0] a, input logic [W-1:0] b);
    ready_i = 0;
    valid_i = 1; data_i = a; cyc();
    data_i = b; cyc();
    valid_i = 0; data_i = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({f_ready, f_valid, f_data, f_usage, f_pending} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_f: got rdy=%b vld=%b dat=%02h use=%0d pend=%b", f_ready, f_valid, f_data, f_usage, f_pending);
    end
    checks++;
    if ({d_ready, d_valid, d_data, d_usage, d_pending} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_d: got rdy=%b vld=%b dat=%02h use=%0d pend=%b", d_ready, d_valid, d_data, d_usage, d_pending);
    end
  endtask

  task automatic test_fill_empty();
    logic [W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    sb_on = 1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; data_i = vals[i]; cyc();
    end
    valid_i = 0;
    #1;
    checks++;
    if (f_usage !== 2'd3 || f_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: got use=%0d rdy=%b expected 3/0", f_usage, f_ready);
    end
    ready_i = 1;
    #1;
    checks++;
    if (f_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ready: got %b expected 0", f_ready);
    end
    for (int i = 0; i < 3; i++) cyc();
    ready_i = 0;
    #1;
    checks++;
    if (f_usage !== 2'd0 || n_pop_f != 3) begin
      errors++;
      $display("FAIL empty_after: got use=%0d pops=%0d expected 0/3", f_usage, n_pop_f);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int start_pops;
    do_reset();
    sb_on = 1;
    start_pops = n_pop_f;
    ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      valid_i = 1; data_i = 8'h40 + W'(i);
      #1;
      if (i > 0) begin
        checks++;
        if (f_valid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble: beat %0d got valid_o=%b expected 1", i, f_valid);
        end
      end
      cyc();
    end
    valid_i = 0;
    cyc();
    cyc();
    checks++;
    if (n_pop_f - start_pops != 10 || exp_f.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: got %0d pops left=%0d expected 10/0", n_pop_f - start_pops, exp_f.size());
    end
    ready_i = 0;
  endtask

  task automatic test_random();
    do_reset();
    sb_on = 1;
    for (int i = 0; i < 150; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = W'($urandom_range(0, 255));
      cyc();
    end
    valid_i = 0; ready_i = 1;
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (exp_f.size() != 0 || f_usage !== 2'd0) begin
      errors++;
      $display("FAIL random_drain: got left=%0d use=%0d expected 0/0", exp_f.size(), f_usage);
    end
    ready_i = 0;
  endtask

  task automatic test_flush_clear();
    int pend;
    do_reset();
    push_two(8'hA1, 8'hB2);
    pend = 0;
    clear_i = 1; cyc();
    clear_i = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (f_pending) pend++;
      if (k < 3) begin
        checks++;
        if (f_pending !== 1'b1 || f_valid !== 1'b0 || f_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_t%0d: got pend=%b vld=%b rdy=%b expected 1/0/0", k, f_pending, f_valid, f_ready);
        end
      end else begin
        checks++;
        if (f_pending !== 1'b0 || f_ready !== 1'b1 || f_usage !== 2'd0 || f_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_t3: got pend=%b rdy=%b use=%0d vld=%b expected 0/1/0/0", f_pending, f_ready, f_usage, f_valid);
        end
      end
      cyc();
    end
    checks++;
    if (pend != 2) begin
      errors++;
      $display("FAIL flush_pending_len: got %0d expected 2", pend);
    end
  endtask

  task automatic test_drain_clear();
    int pend;
    int start_pops;
    do_reset();
    push_two(8'h5A, 8'hC3);
    start_pops = n_pop_d;
    pend = 0;
    clear_i = 1; cyc();
    clear_i = 0; ready_i = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (d_pending) pend++;
      if (k < 4) begin
        checks++;
        if (d_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_ready_t%0d: got %b expected 0", k, d_ready);
        end
      end else begin
        checks++;
        if (d_ready !== 1'b1 || d_usage !== 2'd0) begin
          errors++;
          $display("FAIL drain_done: got rdy=%b use=%0d expected 1/0", d_ready, d_usage);
        end
      end
      cyc();
    end
    ready_i = 0;
    checks++;
    if (pend != 3 || n_pop_d - start_pops != 2) begin
      errors++;
      $display("FAIL drain_seq: got pend=%0d pops=%0d expected 3/2", pend, n_pop_d - start_pops);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    valid_i = 1; data_i = 8'h77; cyc();
    valid_i = 0;
    clear_i = 1; cyc();
    clear_i = 0;
    #1;
    checks++;
    if (f_pending !== 1'b1) begin
      errors++;
      $display("FAIL isolate_entry: got pend=%b expected 1", f_pending);
    end
    rst_n = 0; cyc();
    rst_n = 1;
    exp_f.delete();
    exp_d.delete();
    #1;
    checks++;
    if ({f_ready, f_valid, f_data, f_usage, f_pending} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_f: got rdy=%b vld=%b dat=%02h use=%0d pend=%b", f_ready, f_valid, f_data, f_usage, f_pending);
    end
    checks++;
    if ({d_ready, d_valid, d_data, d_usage, d_pending} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_d: got rdy=%b vld=%b dat=%02h use=%0d pend=%b", d_ready, d_valid, d_data, d_usage, d_pending);
    end
    valid_i = 1; data_i = 8'h66; cyc();
    valid_i = 0;
    clear_i = 1; cyc();
    clear_i = 0; cyc();
    #1;
    checks++;
    if (f_pending !== 1'b1 || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got pend=%b vld=%b expected 1/0", f_pending, f_valid);
    end
    clear_i = 1; cyc();
    clear_i = 0;
    #1;
    checks++;
    if (f_pending !== 1'b0 || f_ready !== 1'b1 || f_usage !== 2'd0) begin
      errors++;
      $display("FAIL ignored_clear_t3: got pend=%b rdy=%b use=%0d expected 0/1/0", f_pending, f_ready, f_usage);
    end
    cyc();
    #1;
    checks++;
    if (f_pending !== 1'b0) begin
      errors++;
      $display("FAIL ignored_clear_t4: got pend=%b expected 0", f_pending);
    end
    cyc();
  endtask

  task automatic test_fall_through();
    do_reset();
    sb_on = 1;
    valid_i = 1; ready_i = 1; data_i = 8'hA5;
    #1;
`ifdef STREAM_FIFO_CLEARABLE_FALL_THROUGH_EN
    checks++;
    if (f_valid !== 1'b1 || f_data !== 8'hA5 || f_usage !== 2'd0) begin
      errors++;
      $display("FAIL ft_same_cycle: got vld=%b dat=%02h use=%0d expected 1/a5/0", f_valid, f_data, f_usage);
    end
    cyc();
    valid_i = 0;
    #1;
    checks++;
    if (f_usage !== 2'd0 || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL ft_after: got use=%0d vld=%b expected 0/0", f_usage, f_valid);
    end
`else
    checks++;
    if (f_valid !== 1'b0 || f_data !== 8'h00) begin
      errors++;
      $display("FAIL latency_same_cycle: got vld=%b dat=%02h expected 0/00", f_valid, f_data);
    end
    cyc();
    valid_i = 0;
    #1;
    checks++;
    if (f_valid !== 1'b1 || f_data !== 8'hA5 || f_usage !== 2'd1) begin
      errors++;
      $display("FAIL latency_next: got vld=%b dat=%02h use=%0d expected 1/a5/1", f_valid, f_data, f_usage);
    end
`endif
    cyc();
    cyc();
    ready_i = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill_empty();
    test_back_to_back();
    test_random();
    test_flush_clear();
    test_drain_clear();
    test_reset_mid_clear();
    test_fall_through();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
